// File: rtl/cp0_timer_ctrl_if.sv
// CP0 access / exception bus between the M stage and the CP0 timer controller.
interface cp0_timer_ctrl_if #(
    parameter int NUM_HWINT = 6
);
    logic [4:0]           rd_addr;
    logic [4:0]           wr_addr;
    logic                 we;
    logic [31:0]          wdata;
    logic [31:0]          pc;
    logic                 bd_in;
    logic [4:0]           exc_code;
    logic [NUM_HWINT-1:0] hw_int;
    logic                 eret;
    logic                 req;
    logic [31:0]          epc;
    logic [31:0]          rdata;
    logic                 timer_irq;

    // Pipeline side: drives accesses and exception info, receives the redirect.
    modport master (
        output rd_addr, wr_addr, we, wdata, pc, bd_in, exc_code, hw_int, eret,
        input  req, epc, rdata, timer_irq
    );

    // CP0 side.
    modport slave (
        input  rd_addr, wr_addr, we, wdata, pc, bd_in, exc_code, hw_int, eret,
        output req, epc, rdata, timer_irq
    );
endinterface

// File: rtl/cp0_timer_ctrl.sv
// CP0 for the pipelined MIPS core: SR/Cause/EPC/PrID, Count/Compare timer,
// two software interrupts, exception/interrupt arbitration and eret exit.
module cp0_timer_ctrl #(
    parameter int          NUM_HWINT  = 6,
    parameter logic [31:0] PRID       = 32'h18373019,
    parameter bit          TIMER_EN   = 1'b1,
    parameter int          TIMER_LINE = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    cp0_timer_ctrl_if.slave   bus
);
    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_SR      = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;
    localparam logic [4:0] A_PRID    = 5'd15;

    // Mask of the IM/IP lines backed by hw_int.
    localparam logic [5:0] HW_MASK = 6'((7'd1 << NUM_HWINT) - 7'd1);
    localparam logic [5:0] TI_BIT  = 6'd1 << TIMER_LINE;

    // Status
    logic [5:0]  im_q, im_d;
    logic [1:0]  swim_q, swim_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  iphw_q, iphw_d;
    logic [1:0]  ipsw_q, ipsw_d;
    logic [4:0]  exccode_q, exccode_d;
    // EPC (word address only) and timer
    logic [29:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;

    logic [5:0]  hw_ext;
    logic        int_req, exc_req, req;
    logic [31:0] epc_new;
    logic        wr_en;
    logic [31:0] sr_val, cause_val;

    // Zero-extend the external lines to the full six-bit IP field.
    always_comb begin
        hw_ext                = '0;
        hw_ext[NUM_HWINT-1:0] = bus.hw_int;
    end

    // Arbitration: interrupts are masked at exception level, exceptions are not.
    always_comb begin
        int_req = (|({iphw_q, ipsw_q} & {im_q, swim_q})) & ie_q & ~exl_q;
        exc_req = |bus.exc_code;
        req     = int_req | exc_req;
        epc_new = bus.bd_in ? (bus.pc - 32'd4) : bus.pc;
        // A redirect squashes the mtc0 issued alongside it.
        wr_en   = bus.we & ~req;
    end

    // Next-state for all CP0 registers.
    always_comb begin
        im_d      = im_q;
        swim_d    = swim_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ipsw_d    = ipsw_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        // Pending hardware lines sampled every cycle, timer folded into its line.
        iphw_d = (hw_ext | (ti_q ? TI_BIT : 6'd0)) & HW_MASK;

        if (req) begin
            exl_d     = 1'b1;
            bd_d      = bus.bd_in;
            epc_d     = epc_new[31:2];
            exccode_d = int_req ? 5'd0 : bus.exc_code;
        end else begin
            if (wr_en && bus.wr_addr == A_SR) begin
                im_d   = bus.wdata[15:10] & HW_MASK;
                swim_d = bus.wdata[9:8];
                exl_d  = bus.wdata[1];
                ie_d   = bus.wdata[0];
            end else if (bus.eret) begin
                exl_d = 1'b0;
            end
            if (wr_en && bus.wr_addr == A_CAUSE) ipsw_d = bus.wdata[9:8];
            if (wr_en && bus.wr_addr == A_EPC)   epc_d  = bus.wdata[31:2];
        end

        if (TIMER_EN) begin
            count_d = (wr_en && bus.wr_addr == A_COUNT) ? bus.wdata : count_q + 32'd1;
            if (wr_en && bus.wr_addr == A_COMPARE) begin
                compare_d = bus.wdata;
                ti_d      = 1'b0;
            end else begin
                ti_d = ti_q | (count_q == compare_q);
            end
        end
    end

    // State registers, async active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im_q      <= '0;
            swim_q    <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ti_q      <= 1'b0;
            iphw_q    <= '0;
            ipsw_q    <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
        end else begin
            im_q      <= im_d;
            swim_q    <= swim_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            iphw_q    <= iphw_d;
            ipsw_q    <= ipsw_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end

    // mfc0 read mux over the pre-update register values.
    always_comb begin
        sr_val    = {16'd0, im_q, swim_q, 6'd0, exl_q, ie_q};
        cause_val = {bd_q, ti_q, 14'd0, iphw_q, ipsw_q, 1'b0, exccode_q, 2'b00};
        case (bus.rd_addr)
            A_COUNT:   bus.rdata = TIMER_EN ? count_q : 32'd0;
            A_COMPARE: bus.rdata = TIMER_EN ? compare_q : 32'd0;
            A_SR:      bus.rdata = sr_val;
            A_CAUSE:   bus.rdata = cause_val;
            A_EPC:     bus.rdata = {epc_q, 2'b00};
            A_PRID:    bus.rdata = PRID;
            default:   bus.rdata = 32'd0;
        endcase
    end

    // Redirect outputs: EPC is forwarded in the cycle the request is raised.
    always_comb begin
        bus.req       = req;
        bus.epc       = req ? epc_new : {epc_q, 2'b00};
        bus.timer_irq = ti_q;
    end
endmodule
